// File: rtl/uart_tx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_tx_ctrl
//
// Register-bus front end for the uart_tx serializer. CPU writes to TXDATA are
// queued in a byte FIFO; a small FSM hands bytes to the serializer one
// tdata/tvld/trdy handshake at a time. STATUS and CTRL are accessible on the
// same bus.
//
// Register map (reg_bus_addr[3:2]):
//   0x0 TXDATA  W   : push wdat[7:0] (dropped and OVF set when full)
//   0x4 STATUS  R   : [0] FULL, [1] EMPTY, [2] BUSY, [3] OVF, [AW+8:8] LEVEL
//   0x8 CTRL    RW  : [0] EN (reset 1), [1] FLUSH pulse, [2] OVF_CLR pulse
//   0xC reserved    : reads 0, writes ignored
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   reg_bus_we/rd         single-cycle write / read strobes
//   reg_bus_addr/wdat     byte address and write data
//   reg_bus_rdat          registered read data, held until the next read
//   tx_tdata/tx_tvld      byte and valid towards uart_tx
//   tx_trdy               serializer ready; transfer on tx_tvld & tx_trdy
//
// Build option:
//   UART_TX_CRLF_EN       when defined, every 8'h0A is preceded by an 8'h0D
// ---------------------------------------------------------------------------
module uart_tx_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter int          DEPTH     = 16,
  parameter int          AW        = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        reg_bus_we,
  input  logic [31:0] reg_bus_addr,
  input  logic [31:0] reg_bus_wdat,
  input  logic        reg_bus_rd,
  output logic [31:0] reg_bus_rdat,
  output logic [7:0]  tx_tdata,
  output logic        tx_tvld,
  input  logic        tx_trdy
);

  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

`ifdef UART_TX_CRLF_EN
  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_PRESENT    = 2'd1,
    S_PRESENT_CR = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESENT = 2'd1
  } state_t;
`endif

  state_t state, state_nxt;

  // FIFO storage and bookkeeping
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   level;
  logic          full, empty;
  logic [7:0]    head;

  // Control / status
  logic          en, ovf;

  // Bus decode
  logic          hit;
  logic [1:0]    reg_sel;
  logic          push_req, ctrl_wr, flush, ovf_clr;
  logic          push, pop, ovf_set;
  logic [31:0]   status, rd_val;

  // FSM side outputs
  logic          load;
  logic [7:0]    load_dat;

`ifdef UART_TX_CRLF_EN
  logic          cr_sent;
  logic          cr_set, cr_clr;
`endif

  // Address bits that never influence behaviour
  logic          unused_bits;
  assign unused_bits = ^{reg_bus_wdat[31:8], reg_bus_addr[1:0]};

  assign full  = (level == FULL_LEVEL);
  assign empty = (level == '0);
  assign head  = mem[rd_ptr];

  assign hit     = (reg_bus_addr[31:4] == BASE_ADDR[31:4]);
  assign reg_sel = reg_bus_addr[3:2];

  assign push_req = reg_bus_we & hit & (reg_sel == 2'd0);
  assign ctrl_wr  = reg_bus_we & hit & (reg_sel == 2'd2);
  assign flush    = ctrl_wr & reg_bus_wdat[1];
  assign ovf_clr  = ctrl_wr & reg_bus_wdat[2];

  // Fullness is judged on the current level only, so a same-cycle pop never
  // makes room for a push. A flush discards any push silently.
  assign push    = push_req & ~full & ~flush;
  assign ovf_set = push_req & full & ~flush;

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= reg_bus_wdat[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  // ---------------------------------------------------------------------------
  // Control and status registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en  <= 1'b1;
      ovf <= 1'b0;
    end else begin
      if (ctrl_wr) en <= reg_bus_wdat[0];
      // An overflow in the same cycle as OVF_CLR keeps the flag set
      if (ovf_set)      ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end

  always_comb begin
    status            = '0;
    status[0]         = full;
    status[1]         = empty;
    status[2]         = ~empty | tx_tvld | ~tx_trdy;
    status[3]         = ovf;
    status[AW+8:8]    = level;
  end

  always_comb begin
    rd_val = '0;
    if (hit) begin
      case (reg_sel)
        2'd1:    rd_val = status;
        2'd2:    rd_val = {31'b0, en};
        default: rd_val = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          reg_bus_rdat <= '0;
    else if (reg_bus_rd) reg_bus_rdat <= rd_val;
  end

  // ---------------------------------------------------------------------------
  // Output FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    load      = 1'b0;
    load_dat  = tx_tdata;
`ifdef UART_TX_CRLF_EN
    cr_set    = 1'b0;
    cr_clr    = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        // A flush in flight wins over launching the head byte
        if (en && !empty && !flush) begin
          load = 1'b1;
`ifdef UART_TX_CRLF_EN
          if (head == 8'h0A && !cr_sent) begin
            // Insert CR ahead of LF; the LF stays at the head for next time
            state_nxt = S_PRESENT_CR;
            load_dat  = 8'h0D;
            cr_set    = 1'b1;
          end else begin
            state_nxt = S_PRESENT;
            load_dat  = head;
            pop       = 1'b1;
            cr_clr    = 1'b1;
          end
`else
          state_nxt = S_PRESENT;
          load_dat  = head;
          pop       = 1'b1;
`endif
        end
      end
      S_PRESENT: begin
        if (tx_trdy) state_nxt = S_IDLE;
      end
`ifdef UART_TX_CRLF_EN
      S_PRESENT_CR: begin
        if (tx_trdy) state_nxt = S_IDLE;
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  // tx_tvld follows the registered state so it drops the cycle after a
  // handshake; tx_tdata only changes when a new byte is launched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_tvld  <= 1'b0;
      tx_tdata <= 8'h00;
    end else begin
      tx_tvld <= (state_nxt != S_IDLE);
      if (load) tx_tdata <= load_dat;
    end
  end

`ifdef UART_TX_CRLF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cr_sent <= 1'b0;
    else if (flush)  cr_sent <= 1'b0;
    else if (cr_set) cr_sent <= 1'b1;
    else if (cr_clr) cr_sent <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_uart_tx_ctrl.sv
module tb_uart_tx_ctrl;

  localparam logic [31:0] BASE = 32'h1000_0000;
  localparam logic [31:0] A_TX = BASE + 32'h0;
  localparam logic [31:0] A_ST = BASE + 32'h4;
  localparam logic [31:0] A_CT = BASE + 32'h8;
  localparam logic [31:0] A_RS = BASE + 32'hC;
  localparam logic [31:0] A_OT = 32'h2000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        we = 1'b0;
  logic        rd = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdat = '0;
  logic [31:0] rdat;
  logic [7:0]  tdata;
  logic        tvld;
  logic        trdy = 1'b1;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0]  seen[$];

  always #5 clk = ~clk;

  uart_tx_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .reg_bus_we   (we),
    .reg_bus_addr (addr),
    .reg_bus_wdat (wdat),
    .reg_bus_rd   (rd),
    .reg_bus_rdat (rdat),
    .tx_tdata     (tdata),
    .tx_tvld      (tvld),
    .tx_trdy      (trdy)
  );

  typedef struct {
    logic        we;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdat;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // All tasks start and end on a falling edge.
  task automatic do_reset();
    we = 1'b0; rd = 1'b0; addr = '0; wdat = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wdat = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic rd_reg(input logic [31:0] a, output logic [31:0] d);
    rd = 1'b1; addr = a;
    @(negedge clk);
    rd = 1'b0;
    d = rdat;
  endtask

  task automatic collect(input int cycles);
    seen.delete();
    for (int c = 0; c < cycles; c++) begin
      if (tvld && trdy) seen.push_back(tdata);
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    int          bad;
    int          highs;

    // Register access vectors (trdy held 1, EN cleared early so bytes stay queued)
    vecs[0]  = '{1'b0, 1'b1, A_ST, 32'h0, 1'b1, 32'h0000_0002};
    vecs[1]  = '{1'b0, 1'b1, A_CT, 32'h0, 1'b1, 32'h0000_0001};
    vecs[2]  = '{1'b0, 1'b1, A_TX, 32'h0, 1'b1, 32'h0000_0000};
    vecs[3]  = '{1'b0, 1'b1, A_RS, 32'h0, 1'b1, 32'h0000_0000};
    vecs[4]  = '{1'b1, 1'b0, A_CT, 32'h0, 1'b0, 32'h0};
    vecs[5]  = '{1'b0, 1'b1, A_CT, 32'h0, 1'b1, 32'h0000_0000};
    vecs[6]  = '{1'b1, 1'b0, A_TX, 32'h41, 1'b0, 32'h0};
    vecs[7]  = '{1'b1, 1'b0, A_TX, 32'h42, 1'b0, 32'h0};
    vecs[8]  = '{1'b0, 1'b1, A_ST, 32'h0, 1'b1, 32'h0000_0204};
    vecs[9]  = '{1'b1, 1'b0, A_OT, 32'h99, 1'b0, 32'h0};
    vecs[10] = '{1'b1, 1'b0, A_RS, 32'hFF, 1'b0, 32'h0};
    vecs[11] = '{1'b0, 1'b1, A_ST, 32'h0, 1'b1, 32'h0000_0204};
    vecs[12] = '{1'b0, 1'b1, A_OT + 32'h4, 32'h0, 1'b1, 32'h0000_0000};
    vecs[13] = '{1'b1, 1'b0, A_CT, 32'h2, 1'b0, 32'h0};
    vecs[14] = '{1'b0, 1'b1, A_ST, 32'h0, 1'b1, 32'h0000_0002};
    vecs[15] = '{1'b0, 1'b0, A_ST, 32'h0, 1'b1, 32'h0000_0002};

    // Reset state
    do_reset();
    check("reset_tvld", {31'b0, tvld}, 32'h0);
    check("reset_tdata", {24'b0, tdata}, 32'h0);
    check("reset_rdat", rdat, 32'h0);

    // Table-driven register accesses
    trdy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      we = vecs[i].we; rd = vecs[i].rd; addr = vecs[i].addr; wdat = vecs[i].wdat;
      @(negedge clk);
      we = 1'b0; rd = 1'b0;
      if (vecs[i].chk) check($sformatf("vec%0d_rdat", i), rdat, vecs[i].exp);
    end
    check("vec_no_tx", {31'b0, tvld}, 32'h0);

    // Basic send
    do_reset();
    trdy = 1'b1;
    wr(A_TX, 32'h41);
    check("basic_tvld_n1", {31'b0, tvld}, 32'h0);
    @(negedge clk);
    check("basic_tvld_n2", {31'b0, tvld}, 32'h1);
    check("basic_tdata", {24'b0, tdata}, 32'h41);
    highs = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (tvld) highs++;
    end
    check("basic_tvld_width", highs, 0);
    rd_reg(A_ST, v);
    check("basic_status", v, 32'h2);

    // Overflow
    do_reset();
    trdy = 1'b0;
    wr(A_CT, 32'h0);
    for (int b = 0; b <= 16; b++) wr(A_TX, b);
    rd_reg(A_ST, v);
    check("ovf_status", v, 32'h0000_100D);
    trdy = 1'b1;
    wr(A_CT, 32'h1);
    collect(80);
    check("ovf_count", seen.size(), 16);
    for (int b = 0; b < 16; b++)
      if (b < seen.size()) check($sformatf("ovf_byte%0d", b), {24'b0, seen[b]}, b);
    rd_reg(A_ST, v);
    check("ovf_sticky", v, 32'hA);
    wr(A_CT, 32'h5);
    rd_reg(A_ST, v);
    check("ovf_cleared", v, 32'h2);

    // Backpressure
    do_reset();
    trdy = 1'b0;
    wr(A_TX, 32'h55);
    @(negedge clk);
    check("bp_tvld", {31'b0, tvld}, 32'h1);
    check("bp_tdata", {24'b0, tdata}, 32'h55);
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (!tvld || tdata != 8'h55) bad++;
    end
    check("bp_stable", bad, 0);
    trdy = 1'b1;
    collect(6);
    check("bp_handshakes", seen.size(), 1);
    if (seen.size() > 0) check("bp_hs_data", {24'b0, seen[0]}, 32'h55);

    // Flush with a byte in flight
    do_reset();
    trdy = 1'b0;
    wr(A_TX, 32'hA1);
    wr(A_TX, 32'hB1);
    wr(A_TX, 32'hC1);
    wr(A_TX, 32'hD1);
    rd_reg(A_ST, v);
    check("fl_pre_status", v, 32'h0000_0304);
    wr(A_CT, 32'h3);
    rd_reg(A_ST, v);
    check("fl_status", v, 32'h6);
    check("fl_inflight_tvld", {31'b0, tvld}, 32'h1);
    check("fl_inflight_tdata", {24'b0, tdata}, 32'hA1);
    trdy = 1'b1;
    collect(8);
    check("fl_handshakes", seen.size(), 1);
    if (seen.size() > 0) check("fl_hs_data", {24'b0, seen[0]}, 32'hA1);
    rd_reg(A_ST, v);
    check("fl_idle_status", v, 32'h2);

    // Line feed handling
    do_reset();
    trdy = 1'b1;
    wr(A_TX, 32'h0A);
    collect(12);
`ifdef UART_TX_CRLF_EN
    check("crlf_count", seen.size(), 2);
    if (seen.size() > 1) begin
      check("crlf_cr", {24'b0, seen[0]}, 32'h0D);
      check("crlf_lf", {24'b0, seen[1]}, 32'h0A);
    end
`else
    check("lf_count", seen.size(), 1);
    if (seen.size() > 0) check("lf_byte", {24'b0, seen[0]}, 32'h0A);
`endif

    // Reset mid-transfer
    do_reset();
    trdy = 1'b0;
    wr(A_CT, 32'h0);
    wr(A_TX, 32'h11);
    wr(A_CT, 32'h1);
    wr(A_TX, 32'h77);
    check("rm_tvld_before", {31'b0, tvld}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("rm_tvld_async", {31'b0, tvld}, 32'h0);
    check("rm_tdata_async", {24'b0, tdata}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    trdy = 1'b1;
    @(negedge clk);
    rd_reg(A_ST, v);
    check("rm_status", v, 32'h2);
    rd_reg(A_CT, v);
    check("rm_ctrl", v, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
